// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment reader: segment patterns {a,b,c,d,e,f,g},
// the invalid-digit code and the frame FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder; unknown patterns (blank
// included) flag invalid and return BCD_INVALID.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] bcd_o,
    output logic       invalid_o
);

    always_comb begin
        bcd_o     = BCD_INVALID;
        invalid_o = 1'b0;
        case (pat_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_reader.sv
// Multiplexed 7-segment bus reader: debounces each digit strobe, decodes it back to
// BCD and offers whole frames on valid/ready. SEG7_ERR_EN adds the err output.
module seg7_bcd_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a,
    input  logic                  b,
    input  logic                  c,
    input  logic                  d,
    input  logic                  e,
    input  logic                  f,
    input  logic                  g,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SEG7_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [6:0]          pat_in;
    logic [6+DIGITS:0]   samp_in;
    logic [6+DIGITS:0]   samp_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sel_ok;
    logic                accept;
    logic                pattern_ok;
    logic [3:0]          dec_bcd;
    logic                dec_invalid;
    logic [4*DIGITS-1:0] slots_q;
    logic [DIGITS-1:0]   captured_q, captured_d;
    logic                frame_done;
    state_e              state_q;
    logic [4*DIGITS-1:0] bcd_out_q;
    logic                out_valid_q;

    assign pat_in  = {a, b, c, d, e, f, g};
    assign samp_in = {pat_in, dig_sel};
    assign sel_ok  = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);

    seg7_pattern_decode u_decode (
        .pat_i     (pat_in),
        .bcd_o     (dec_bcd),
        .invalid_o (dec_invalid)
    );

`ifdef SEG7_ERR_EN
    assign pattern_ok = 1'b1;
`else
    assign pattern_ok = !dec_invalid;
`endif

    // Counter saturates at CNT_MAX so a long dwell is accepted exactly once.
    always_comb begin
        cnt_d = '0;
        if (sel_ok && (samp_in == samp_q)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    assign accept     = sel_ok && pattern_ok && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    assign frame_done = (state_q == COLLECT) && (&captured_q);

    // A capture landing on the copy cycle belongs to the next frame, so it wins over the clear.
    always_comb begin
        captured_d = captured_q;
        if (frame_done) captured_d = '0;
        if (accept) captured_d = captured_d | dig_sel;
    end

`ifdef SEG7_ERR_EN
    logic [DIGITS-1:0] inv_q;
    logic              err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q     <= '0;
            cnt_q      <= '0;
            captured_q <= '0;
            slots_q    <= '0;
`ifdef SEG7_ERR_EN
            inv_q      <= '0;
`endif
        end else begin
            samp_q     <= samp_in;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            for (int i = 0; i < DIGITS; i++) begin
                if (accept && dig_sel[i]) begin
                    slots_q[4*i +: 4] <= dec_bcd;
`ifdef SEG7_ERR_EN
                    inv_q[i]          <= dec_invalid;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            bcd_out_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef SEG7_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (&captured_q) begin
                        bcd_out_q   <= slots_q;
                        out_valid_q <= 1'b1;
                        state_q     <= OFFER;
`ifdef SEG7_ERR_EN
                        err_q       <= |inv_q;
`endif
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bcd_out   = bcd_out_q;
    assign out_valid = out_valid_q;
`ifdef SEG7_ERR_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// Bench for seg7_bcd_reader: directed scenarios plus random dwells, checked by a
// frame-level reference model and an expected-frame queue. Honours SEG7_ERR_EN.
module tb_seg7_bcd_reader;

    localparam int D = 4;
    localparam int S = 4;
`ifdef SEG7_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [6:0] PATS [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       seg;
    logic [D-1:0]     sel;
    logic             out_ready;
    logic [4*D-1:0]   bcd_out;
    logic             out_valid;
    logic             err_act;
`ifdef SEG7_ERR_EN
    logic             err;
    assign err_act = err;
`else
    assign err_act = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_bcd_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (seg[6]),
        .b         (seg[5]),
        .c         (seg[4]),
        .d         (seg[3]),
        .e         (seg[2]),
        .f         (seg[1]),
        .g         (seg[0]),
        .dig_sel   (sel),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SEG7_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 10; k++) begin
            if (p == PATS[k]) return {1'b0, 4'(k)};
        end
        return {1'b1, 4'hF};
    endfunction

    logic [4*D:0]   exp_q[$];
    logic [4*D-1:0] hs_log[$];

    logic [6+D:0]   m_prev = '0;
    bit             m_have_prev = 0;
    int             m_run = 0;
    logic [3:0]     m_slot [D];
    bit             m_inv  [D];
    bit             m_capt [D];
    bit             m_valid = 0;
    logic [4*D-1:0] m_out = '0;
    bit             m_err = 0;

    always @(posedge clk) begin
        logic [6+D:0] cur;
        logic [4:0]   dec;
        logic [4*D-1:0] frame;
        bit all_c;
        bit any_inv;
        cur = {seg, sel};
        if (rst) begin
            m_have_prev = 0;
            m_run = 0;
            m_valid = 0;
            m_out = '0;
            m_err = 0;
            for (int k = 0; k < D; k++) begin
                m_slot[k] = 4'h0;
                m_inv[k] = 0;
                m_capt[k] = 0;
            end
            exp_q.delete();
        end else begin
            all_c = 1;
            for (int k = 0; k < D; k++) if (!m_capt[k]) all_c = 0;
            if (m_valid) begin
                if (out_ready) m_valid = 0;
            end else if (all_c) begin
                any_inv = 0;
                for (int k = 0; k < D; k++) begin
                    frame[4*k +: 4] = m_slot[k];
                    any_inv |= m_inv[k];
                    m_capt[k] = 0;
                end
                m_out = frame;
                m_err = ERR_EN && any_inv;
                m_valid = 1;
                exp_q.push_back({m_err, frame});
            end
            if (m_have_prev && cur == m_prev) m_run++;
            else m_run = 1;
            m_prev = cur;
            m_have_prev = 1;
            dec = ref_decode(seg);
            if ($onehot(sel) && m_run == S && (ERR_EN || !dec[4])) begin
                for (int k = 0; k < D; k++) begin
                    if (sel[k]) begin
                        m_slot[k] = dec[3:0];
                        m_inv[k] = dec[4];
                        m_capt[k] = 1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [4*D:0] e;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("bcd_out", 64'(bcd_out), 64'(m_out));
`ifdef SEG7_ERR_EN
        check("err", 64'(err), 64'(m_err));
`endif
        if (out_valid && out_ready && !rst) begin
            hs_log.push_back(bcd_out);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'({err_act, bcd_out}), 64'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check("frame", 64'({err_act, bcd_out}), 64'(e));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic show_raw(input logic [D-1:0] s, input logic [6:0] p, input int n);
        seg = p;
        sel = s;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic show(input int slot, input int digit, input int n);
        show_raw(D'(1) << slot, PATS[digit], n);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic frame4(input int d0, input int d1, input int d2, input int d3);
        show(0, d0, 8);
        show(1, d1, 8);
        show(2, d2, 8);
        show(3, d3, 8);
    endtask

    function automatic logic [4*D-1:0] last_hs();
        if (hs_log.size() == 0) return '1;
        return hs_log[$];
    endfunction

    initial begin
        int n0;
        rst = 1'b1;
        seg = '0;
        sel = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_bcd", 64'(bcd_out), 64'd0);
        rst = 1'b0;

        // Clean frame
        frame4(1, 2, 3, 4);
        show_raw('0, 7'd0, 4);
        check("clean_count", 64'(hs_log.size()), 64'd1);
        check("clean_value", 64'(last_hs()), 64'h4321);

        // Short dwell on slot 2
        n0 = hs_log.size();
        show(0, 1, 8);
        show(1, 2, 8);
        show(2, 3, 3);
        show(3, 4, 8);
        show_raw('0, 7'd0, 4);
        check("short_dwell_held", 64'(hs_log.size()), 64'(n0));
        show(2, 3, 4);
        show_raw('0, 7'd0, 4);
        check("short_dwell_count", 64'(hs_log.size()), 64'(n0 + 1));
        check("short_dwell_value", 64'(last_hs()), 64'h4321);

        // Backpressure: two frames complete while stalled
        n0 = hs_log.size();
        out_ready = 1'b0;
        frame4(5, 6, 7, 8);
        frame4(9, 0, 1, 2);
        show_raw('0, 7'd0, 4);
        check("bp_hold_value", 64'(bcd_out), 64'h8765);
        out_ready = 1'b1;
        show_raw('0, 7'd0, 1);
        out_ready = 1'b0;
        show_raw('0, 7'd0, 3);
        check("bp_second_offer", 64'(bcd_out), 64'h2109);
        out_ready = 1'b1;
        show_raw('0, 7'd0, 3);
        check("bp_count", 64'(hs_log.size()), 64'(n0 + 2));
        check("bp_value", 64'(last_hs()), 64'h2109);

        // Invalid (blank) pattern in slot 1
        n0 = hs_log.size();
        show(0, 5, 8);
        show_raw(D'(2), 7'b0000000, 8);
        show(2, 7, 8);
        show(3, 8, 8);
        show_raw('0, 7'd0, 4);
`ifdef SEG7_ERR_EN
        check("invalid_count", 64'(hs_log.size()), 64'(n0 + 1));
        check("invalid_value", 64'(last_hs()), 64'h87F5);
`else
        check("invalid_withheld", 64'(hs_log.size()), 64'(n0));
        show(1, 1, 8);
        show_raw('0, 7'd0, 4);
        check("invalid_fixed_value", 64'(last_hs()), 64'h8715);
`endif
        pulse_reset();

        // Bad strobes
        n0 = hs_log.size();
        show_raw(D'(6), PATS[8], 10);
        show_raw('0, PATS[8], 10);
        show(1, 3, 8);
        show(2, 3, 8);
        show(3, 3, 8);
        show_raw('0, 7'd0, 4);
        check("bad_strobe_held", 64'(hs_log.size()), 64'(n0));
        show(0, 3, 8);
        show_raw('0, 7'd0, 4);
        check("bad_strobe_value", 64'(last_hs()), 64'h3333);

        // Reset mid-frame and during offer
        n0 = hs_log.size();
        show(0, 9, 8);
        show(1, 8, 8);
        show(2, 7, 8);
        show_raw('0, 7'd0, 1);
        pulse_reset();
        show(3, 6, 8);
        show_raw('0, 7'd0, 4);
        check("rst_mid_held", 64'(hs_log.size()), 64'(n0));
        out_ready = 1'b0;
        frame4(2, 4, 6, 8);
        show_raw('0, 7'd0, 2);
        check("rst_offer_valid_before", 64'(out_valid), 64'd1);
        pulse_reset();
        check("rst_offer_valid_after", 64'(out_valid), 64'd0);
        check("rst_offer_bcd_after", 64'(bcd_out), 64'd0);
        out_ready = 1'b1;
        show_raw('0, 7'd0, 4);
        check("rst_offer_no_hs", 64'(hs_log.size()), 64'(n0));
        frame4(0, 1, 0, 1);
        show_raw('0, 7'd0, 4);
        check("rst_fresh_value", 64'(last_hs()), 64'h1010);

        // Random dwells
        for (int t = 0; t < 400; t++) begin
            int r;
            int slot;
            logic [6:0] p;
            logic [D-1:0] s;
            r = $urandom_range(99, 0);
            slot = $urandom_range(D - 1, 0);
            p = PATS[$urandom_range(9, 0)];
            s = D'(1) << slot;
            if (r < 6) p = 7'($urandom());
            else if (r < 10) p = 7'b0000000;
            if (r >= 90 && r < 96) s = D'($urandom());
            out_ready = ($urandom_range(2, 0) != 0);
            if (r == 99) pulse_reset();
            show_raw(s, p, $urandom_range(8, 1));
        end

        out_ready = 1'b1;
        show_raw('0, 7'd0, 20);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
